serial_receiver: RTL and testbench
==================================

Name: serial_receiver

Overview:
- UART receiver, 8N1 (one start bit, eight data bits LSB first, one stop bit) on a single serial line.
- Used as the host-side monitor of the system's TXD line.
- Deserialises frames into a byte register with a one-cycle completion strobe.
- Holds a sticky ready flag that the consumer clears with a read strobe.

Parameters:
- CLKS_PER_BIT, 16, m_clock cycles per serial bit. Must be ≥4 and even.

Ports:
- m_clock  in  1  system clock; all logic on its rising edge.
- p_reset  in  1  reset, asynchronous, active-low.
- rxd  in  1  serial input; idles high; asynchronous to m_clock.
- port_read  in  1  consumer read strobe; clears rxready.
- data  out  8  last correctly received byte.
- done  out  1  one-cycle pulse when a byte has been captured.
- rxready  out  1  sticky "byte available" flag.

Behaviour:
- Reset (p_reset=0, asynchronous):
  - data=0x00, done=0, rxready=0.
  - FSM goes to IDLE; counters clear.
  - Synchroniser flops preset to 1.
- rxd passes through a 2-flop synchroniser; all references to "line" below mean the synchronised value.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when line=0, load bit counter with CLKS_PER_BIT/2-1 and go to START.
- START: count down. At zero, sample the line:
  - line=0: reload counter with CLKS_PER_BIT-1, bit index=0, go to DATA.
  - line=1: glitch; return to IDLE, no output change.
- DATA:
  - At each counter zero, sample the line into shift-register bit[index] (LSB first) and reload the counter.
  - After index 7, go to STOP.
- STOP: at counter zero, sample the line (mid stop bit):
  - line=1: next edge data←shift register, done=1 for exactly one cycle, rxready=1; go to IDLE. Back-to-back frames are accepted; the next start edge may arrive half a bit later.
  - line=0: framing error (see Optional Feature).
- WAIT_HIGH: stay until line=1, then go to IDLE. Prevents a break condition from being decoded as repeated frames.
- rxready:
  - Set on the done cycle.
  - Cleared on the cycle after port_read=1.
  - If a completion and port_read occur in the same cycle, set wins and rxready stays 1.
- Overrun: a new byte overwrites data even while rxready=1; no error indication.
- port_read has no effect on the FSM or data.
- Sample point latency: the first data-bit sample is taken 1.5·CLKS_PER_BIT (±1) cycles after the synchronised falling edge, plus 2 synchroniser cycles.
- done rises CLKS_PER_BIT/2 + 1 cycles into the stop bit, ±2.
- Reset asserted mid-frame aborts the frame immediately; no done pulse.

Optional Feature:
- Macro: SERIAL_RX_FRAMING_CHECK_EN.
- Defined: stop bit sampled 0 discards the frame. No done, data and rxready unchanged; go to WAIT_HIGH.
- Not defined: stop bit value is ignored. The byte is delivered exactly as for a valid stop bit (done, data, rxready), then go to WAIT_HIGH if line=0, else IDLE.

Test Plan (CLKS_PER_BIT=16 unless noted):
- Reset release, line idle 200 cycles -> data=0x00, done never 1, rxready=0.
- Send 0x41 (start, 1,0,0,0,0,0,1,0, stop) -> exactly one done pulse about 152 cycles after start edge, data=0x41, rxready=1. port_read pulse -> rxready=0 next cycle, data stays 0x41.
- Send 0x55 then 0xAA back-to-back with no idle, without port_read -> two done pulses; data=0xAA after second; rxready=1 throughout. Assert port_read on the cycle of the second done -> rxready stays 1.
- Line low 5 cycles then high -> no done; FSM back in IDLE; a following 0x3C is received correctly.
- Frame 0x7E with stop bit 0, then line held low 100 cycles, then high:
  - With macro: no done, data unchanged, no spurious frames during the low period.
  - Without macro: one done with data=0x7E, no further frames until line returns high.
- Assert p_reset during data bit 3 of 0xFF, release, then send 0x12 -> outputs zero during reset, no done for the aborted frame, then data=0x12 with one done pulse.

Source files
------------

// File: rtl/serial_receiver_if.sv
// Serial receiver bundle: line in, consumer read strobe in, received byte and status out.
// The DUT side uses the slave modport; the host/testbench side uses master.
interface serial_receiver_if;
  logic       rxd;
  logic       port_read;
  logic [7:0] data;
  logic       done;
  logic       rxready;

  modport master (
    output rxd,
    output port_read,
    input  data,
    input  done,
    input  rxready
  );

  modport slave (
    input  rxd,
    input  port_read,
    output data,
    output done,
    output rxready
  );
endinterface

// File: rtl/serial_receiver.sv
// 8N1 UART receiver: 2-flop line synchroniser, mid-bit sampling FSM, byte register,
// one-cycle done strobe and sticky rxready. Optional SERIAL_RX_FRAMING_CHECK_EN drops bad-stop frames.
//
// state     | meaning
// IDLE      | line high, waiting for a start edge
// START     | half-bit wait, confirm start bit at its centre
// DATA      | sample eight data bits at bit centres, LSB first
// STOP      | sample stop bit centre, deliver byte
// WAIT_HIGH | line stuck low after a frame; wait for it to return high
module serial_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              m_clock,
  input  logic              p_reset,
  serial_receiver_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state_q;
  logic          rxd_s1_q;
  logic          rxd_s2_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          done_q;
  logic          rxready_q;
  logic          line;

  assign line        = rxd_s2_q;
  assign bus.data    = data_q;
  assign bus.done    = done_q;
  assign bus.rxready = rxready_q;

  // Synchroniser presets to idle-high so reset release never looks like a start edge
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      rxd_s1_q <= bus.rxd;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      rxready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A delivery later in this block overrides the clear, so set wins over read
      if (bus.port_read) rxready_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!line) begin
            cnt_q   <= HALF_LD;
            state_q <= START;
          end
        end

        START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (!line) begin
            cnt_q   <= FULL_LD;
            idx_q   <= '0;
            state_q <= DATA;
          end else begin
            state_q <= IDLE;
          end
        end

        DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            shift_q[idx_q] <= line;
            cnt_q          <= FULL_LD;
            if (idx_q == 3'd7) state_q <= STOP;
            else               idx_q   <= idx_q + 3'd1;
          end
        end

        STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (line) begin
            data_q    <= shift_q;
            done_q    <= 1'b1;
            rxready_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
`ifdef SERIAL_RX_FRAMING_CHECK_EN
            state_q   <= WAIT_HIGH;
`else
            data_q    <= shift_q;
            done_q    <= 1'b1;
            rxready_q <= 1'b1;
            state_q   <= WAIT_HIGH;
`endif
          end
        end

        WAIT_HIGH: begin
          if (line) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed self-checking bench for serial_receiver at CLKS_PER_BIT=16.
module tb_serial_receiver;

  localparam int CPB = 16;

  logic m_clock = 1'b0;
  logic p_reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  int   done_hi  = 0;
  logic done_prev = 1'b0;

  serial_receiver_if bus ();

  serial_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .bus     (bus)
  );

  always #5 m_clock = ~m_clock;

  always @(negedge m_clock) begin
    if (bus.done && !done_prev) pulses++;
    if (bus.done) done_hi++;
    done_prev = bus.done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting at a negedge; rd_c >= 0 pulses port_read for one cycle
  // at that offset into the stop bit. Reports the cycle offset where done was seen.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int rd_c,
                            output int done_at, output logic rdy_at_done);
    logic [9:0] fr;
    int cyc;
    fr = {stop_v, b, 1'b0};
    cyc = 0;
    done_at = -1;
    rdy_at_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.rxd = fr[i];
      for (int c = 0; c < CPB; c++) begin
        bus.port_read = (i == 9 && c == rd_c) ? 1'b1 : 1'b0;
        @(negedge m_clock);
        cyc++;
        if (bus.done === 1'b1 && done_at < 0) begin
          done_at = cyc;
          rdy_at_done = bus.rxready;
        end
      end
    end
    bus.port_read = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rxd = 1'b1;
    repeat (n) @(negedge m_clock);
  endtask

  int   d_at;
  logic r_at;
  int   p0;
  logic [7:0] data_before;

  initial begin
    p_reset = 1'b0;
    bus.rxd = 1'b1;
    bus.port_read = 1'b0;
    repeat (3) @(negedge m_clock);
    check("reset_data", bus.data, 8'h00);
    check("reset_rxready", bus.rxready, 1'b0);
    p_reset = 1'b1;
    idle(200);
    check("idle_pulses", pulses, 0);
    check("idle_data", bus.data, 8'h00);
    check("idle_rxready", bus.rxready, 1'b0);

    // Single frame 0x41, then consumer read
    send_frame(8'h41, 1'b1, -1, d_at, r_at);
    check("f41_latency_in_window", (d_at >= 150 && d_at <= 158), 1'b1);
    check("f41_rdy_at_done", r_at, 1'b1);
    check("f41_pulses", pulses, 1);
    check("f41_data", bus.data, 8'h41);
    check("f41_rxready", bus.rxready, 1'b1);
    bus.port_read = 1'b1;
    @(negedge m_clock);
    bus.port_read = 1'b0;
    check("read_clears_rxready", bus.rxready, 1'b0);
    check("read_keeps_data", bus.data, 8'h41);
    idle(20);

    // Back-to-back 0x55, 0xAA; read strobe coincides with the second completion edge
    send_frame(8'h55, 1'b1, -1, d_at, r_at);
    check("f55_data", bus.data, 8'h55);
    check("f55_rxready", bus.rxready, 1'b1);
    check("f55_pulses", pulses, 2);
    send_frame(8'hAA, 1'b1, 10, d_at, r_at);
    check("fAA_done_after_read", d_at, 155);
    check("fAA_rdy_at_done", r_at, 1'b1);
    idle(20);
    check("fAA_data", bus.data, 8'hAA);
    check("fAA_pulses", pulses, 3);
    check("set_wins_rxready", bus.rxready, 1'b1);

    // Start glitch of 5 cycles, then a valid frame
    bus.rxd = 1'b0;
    repeat (5) @(negedge m_clock);
    idle(40);
    check("glitch_pulses", pulses, 3);
    check("glitch_data", bus.data, 8'hAA);
    send_frame(8'h3C, 1'b1, -1, d_at, r_at);
    idle(20);
    check("f3C_data", bus.data, 8'h3C);
    check("f3C_pulses", pulses, 4);

    // Frame with bad stop bit followed by a long break
    p0 = pulses;
    data_before = bus.data;
    send_frame(8'h7E, 1'b0, -1, d_at, r_at);
    bus.rxd = 1'b0;
    repeat (100) @(negedge m_clock);
    idle(40);
`ifdef SERIAL_RX_FRAMING_CHECK_EN
    check("frame_err_pulses", pulses, p0);
    check("frame_err_data", bus.data, data_before);
`else
    check("frame_err_pulses", pulses, p0 + 1);
    check("frame_err_data", bus.data, 8'h7E);
`endif
    check("frame_err_rxready", bus.rxready, 1'b1);

    // Reset in the middle of data bit 3 of 0xFF
    p0 = pulses;
    bus.rxd = 1'b0;
    repeat (CPB) @(negedge m_clock);
    bus.rxd = 1'b1;
    repeat (CPB * 3 + 8) @(negedge m_clock);
    p_reset = 1'b0;
    repeat (2) @(negedge m_clock);
    check("midreset_data", bus.data, 8'h00);
    check("midreset_done", bus.done, 1'b0);
    check("midreset_rxready", bus.rxready, 1'b0);
    p_reset = 1'b1;
    idle(200);
    check("abort_no_done", pulses, p0);
    send_frame(8'h12, 1'b1, -1, d_at, r_at);
    idle(20);
    check("f12_data", bus.data, 8'h12);
    check("f12_pulses", pulses, p0 + 1);
    check("done_one_cycle", done_hi, pulses);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
